fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// - Instruction fetch controller. Sequences the 32x16 program memory: owns the PC, drives the async-read address,
//   latches the word into an instruction register and hands it to execute with a valid/ready handshake.
// - Applies PC-relative branch redirects and run/single-step/halt control. Sits between program memory and the execute stage.
// PARAMETERS
// - PC_W          5        PC / program-memory address width (32 words)
// - INSTR_W       16       instruction width
// - HALT_ON_WORD  1        1: halt after retiring an instruction equal to HALT_WORD
// - HALT_WORD     16'h0000 halt sentinel (unused PM words are zero-filled)
// - CNT_W         16       retired-instruction counter width
// PORTS
// - clk            in   1        rising-edge clock
// - rst            in   1        synchronous, active-high reset
// - run            in   1        level; 1 = free-run fetch
// - step           in   1        1-cycle pulse; fetches one instruction while run=0
// - pm_addr        out  PC_W     program-memory address (= pc, combinational)
// - pm_data        in   INSTR_W  program-memory read data, valid in the same cycle as pm_addr
// - instr          out  INSTR_W  issued instruction (registered)
// - instr_pc       out  PC_W     address of instr (registered)
// - instr_valid    out  1        instr is offered to execute
// - instr_ready    in   1        execute accepts instr
// - branch_taken   in   1        qualifies the accepted instr as a taken branch
// - branch_offset  in   8        signed offset relative to instr_pc
// - halt_req       in   1        external halt request
// - halted         out  1        sequencer is stopped
// - retired_count  out  CNT_W    instructions accepted since reset, saturating
// BEHAVIOUR
// - Clock and reset: single clock domain; rst is synchronous, active-high.
// - Reset values: pc=0, state=FETCH, instr=0, instr_pc=0, instr_valid=0, halted=0, retired_count=0, step_pending=0.
//   rst asserted mid-operation discards the held instruction and any pending step.
// - States:
//   - FETCH: default after reset.
//   - ISSUE: instr_valid=1, decoded from state.
//   - HALT: halted=1, decoded from state. Terminal; exited only by rst.
// - step_pending: set by a step pulse in FETCH/ISSUE while run=0. Cleared when FETCH consumes it. Steps in HALT are ignored.
// - FETCH: if run|step_pending, then instr<=pm_data, instr_pc<=pc, clear step_pending, go ISSUE. Otherwise hold.
// - ISSUE: hold instr, instr_pc and instr_valid stable until instr_ready. On handshake (valid&ready):
//   - retired_count+1, saturating at all-ones.
//   - pc <= branch_taken ? instr_pc+sext(branch_offset) : instr_pc+1, both mod 2^PC_W (31+1 -> 0; 3-5 -> 30).
//   - next state: HALT if (HALT_ON_WORD && instr==HALT_WORD) or halt_req; otherwise FETCH.
//   - branch_taken and branch_offset are ignored outside a handshake.
// - halt_req priority:
//   - In FETCH: -> HALT next edge; no instruction is issued.
//   - In ISSUE without handshake: -> HALT next edge; the held instruction is dropped and not counted.
//   - Same cycle as a handshake: the instruction retires and pc updates first, then HALT.
// - Latency: minimum 2 cycles per instruction (FETCH, ISSUE with ready=1). pm_data is sampled only in FETCH.
// - In HALT: instr_valid=0. pc, instr and retired_count hold.
// STRUCTURE
// - Shared cpu_pkg holds:
//   - constants PC_W, INSTR_W, OPC_MSB=15, OPC_LSB=11
//   - state encoding FETCH=2'd0, ISSUE=2'd1, HALT=2'd2
//   - HALT_WORD default
// - One sub-module: sat_counter (CNT_W, inc, clr), used for retired_count.
// - PC adder and FSM are inline. pm_addr is a plain wire from pc; no memory instance inside this block.
// TESTING
// - T1 reset/run, ready=1, PM[0..2]=MOVI/MOVI/ADDI then zeros:
//   - issue pcs 0,1,2,3
//   - word at pc 3 = 0x0000 -> halted=1
//   - retired_count=4
// - T2 backpressure: ready=0 for 5 cycles in ISSUE -> instr/instr_pc stable, valid=1, count unchanged; accepted exactly once.
// - T3 branch: accept instr_pc=22 with branch_taken=1, offset=+2 -> next fetch at pc 24; pc 23 never issued.
// - T4 wrap and negative offset:
//   - accept at pc 31 without branch -> next fetch at pc 0
//   - accept at pc 3 with offset=-5 -> next fetch at pc 30
// - T5 single-step, run=0:
//   - no step -> stays in FETCH, valid=0
//   - one step pulse -> exactly one instruction issued, then back to FETCH idle
// - T6 halt priority:
//   - halt_req in ISSUE without ready -> HALT, count unchanged
//   - halt_req with handshake -> count+1, pc advanced, HALT
//   - rst in HALT -> pc=0, state=FETCH

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the small CPU slice: program-memory
//               geometry, opcode field position, fetch-sequencer state
//               encoding and the default halt sentinel word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Program memory is 32 words of 16 bits.
    localparam int PC_W    = 5;
    localparam int INSTR_W = 16;

    // Opcode field inside an instruction word.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;

    // Fetch sequencer state encoding.
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Unused program-memory words are zero-filled, so an all-zero word
    // doubles as the end-of-program marker.
    localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Ports       : clk   - rising-edge clock
//               rst   - synchronous active-high reset (count -> 0)
//               inc   - add one this cycle (ignored once saturated)
//               clr   - synchronous clear, wins over inc
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch controller. Owns the PC, drives the
//               asynchronous program-memory read address, captures the word
//               into an instruction register and offers it to execute with a
//               valid/ready handshake. Applies PC-relative branch redirects
//               and run / single-step / halt control.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               run, step              - free-run level, single-step pulse
//               pm_addr / pm_data      - program-memory read port
//               instr, instr_pc        - issued instruction and its address
//               instr_valid/instr_ready- handshake with execute
//               branch_taken/_offset   - redirect qualifier for accepted instr
//               halt_req, halted       - external halt request, stopped flag
//               retired_count          - accepted instructions, saturating
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int                  PC_W         = cpu_pkg::PC_W,
    parameter int                  INSTR_W      = cpu_pkg::INSTR_W,
    parameter bit                  HALT_ON_WORD = 1'b1,
    parameter logic [INSTR_W-1:0]  HALT_WORD    = cpu_pkg::HALT_WORD,
    parameter int                  CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    output logic [PC_W-1:0]    pm_addr,
    input  logic [INSTR_W-1:0] pm_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [7:0]         branch_offset,
    input  logic               halt_req,
    output logic               halted,
    output logic [CNT_W-1:0]   retired_count
);

    import cpu_pkg::*;

    logic [1:0]         state_q,        state_d;
    logic [PC_W-1:0]    pc_q,           pc_d;
    logic [INSTR_W-1:0] instr_q,        instr_d;
    logic [PC_W-1:0]    instr_pc_q,     instr_pc_d;
    logic               step_pending_q, step_pending_d;

    logic               handshake;
    logic               fetch_go;
    logic               is_halt_word;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    seq_target;

    // A halt request seen in FETCH pre-empts the fetch entirely.
    assign handshake    = (state_q == ST_ISSUE) && instr_ready;
    assign fetch_go     = (state_q == ST_FETCH) && !halt_req && (run || step_pending_q);
    assign is_halt_word = HALT_ON_WORD && (instr_q == HALT_WORD);

    // Sized signed cast sign-extends (or truncates) the offset to PC width;
    // the add then wraps naturally modulo 2^PC_W.
    assign branch_target = instr_pc_q + PC_W'($signed(branch_offset));
    assign seq_target    = instr_pc_q + PC_W'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FETCH;
            pc_q           <= '0;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            step_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            step_pending_q <= step_pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        step_pending_d = step_pending_q;

        case (state_q)
            ST_FETCH: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (fetch_go) begin
                    instr_d        = pm_data;
                    instr_pc_d     = pc_q;
                    step_pending_d = 1'b0;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    // Retire first, then decide whether to stop.
                    pc_d    = branch_taken ? branch_target : seq_target;
                    state_d = (is_halt_word || halt_req) ? ST_HALT : ST_FETCH;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // A new step pulse is remembered even in the cycle that consumes
        // an older one, so back-to-back pulses are not lost.
        if (step && !run && ((state_q == ST_FETCH) || (state_q == ST_ISSUE))) begin
            step_pending_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        instr_valid = (state_q == ST_ISSUE);
        halted      = (state_q == ST_HALT);
    end

    assign pm_addr  = pc_q;
    assign instr    = instr_q;
    assign instr_pc = instr_pc_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_retired_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (handshake),
        .clr   (1'b0),
        .count (retired_count)
    );

endmodule : fetch_sequencer

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer with a
//               combinational 32x16 program-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step;
    logic [4:0]  pm_addr;
    logic [15:0] pm_data;
    logic [15:0] instr;
    logic [4:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [7:0]  branch_offset;
    logic        halt_req;
    logic        halted;
    logic [15:0] retired_count;

    logic [15:0] pm [32];

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    assign pm_data = pm[pm_addr];

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .step          (step),
        .pm_addr       (pm_addr),
        .pm_data       (pm_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .halt_req      (halt_req),
        .halted        (halted),
        .retired_count (retired_count)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        run           = 1'b0;
        step          = 1'b0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 8'd0;
        halt_req      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Fill every word with a non-zero pattern so nothing halts by accident.
    task automatic fill_pm();
        for (int i = 0; i < 32; i++) pm[i] = 16'h4000 | 16'(i);
    endtask

    // Bounded wait for instr_valid; callers check instr_valid afterwards.
    task automatic wait_valid();
        for (int n = 0; n < 8 && instr_valid !== 1'b1; n++) tick();
    endtask

    task automatic test_reset();
        fill_pm();
        do_reset();
        tests_run++;
        if (pm_addr !== 5'd0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
            retired_count !== 16'd0 || instr !== 16'd0 || instr_pc !== 5'd0) begin
            fails++;
            $display("FAIL reset: pm_addr=%0d valid=%b halted=%b cnt=%0d instr=%h instr_pc=%0d, required 0/0/0/0/0000/0",
                     pm_addr, instr_valid, halted, retired_count, instr, instr_pc);
        end
    endtask

    task automatic test_run_halt_word();
        logic [15:0] exp_instr [4];
        exp_instr[0] = 16'h0801;
        exp_instr[1] = 16'h0A02;
        exp_instr[2] = 16'h1003;
        exp_instr[3] = 16'h0000;
        for (int i = 0; i < 32; i++) pm[i] = 16'h0000;
        pm[0] = 16'h0801;
        pm[1] = 16'h0A02;
        pm[2] = 16'h1003;
        do_reset();
        run         = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid();
            tests_run++;
            if (instr_valid !== 1'b1 || instr_pc !== 5'(k) || instr !== exp_instr[k]) begin
                fails++;
                $display("FAIL run_issue[%0d]: valid=%b pc=%0d instr=%h, required 1/%0d/%h",
                         k, instr_valid, instr_pc, instr, k, exp_instr[k]);
            end
            tick();
        end
        tests_run++;
        if (halted !== 1'b1 || retired_count !== 16'd4 || instr_valid !== 1'b0 || pm_addr !== 5'd4) begin
            fails++;
            $display("FAIL run_halt_word: halted=%b cnt=%0d valid=%b pc=%0d, required 1/4/0/4",
                     halted, retired_count, instr_valid, pm_addr);
        end
        tick();
        tick();
        tests_run++;
        if (halted !== 1'b1 || retired_count !== 16'd4 || pm_addr !== 5'd4) begin
            fails++;
            $display("FAIL halt_hold: halted=%b cnt=%0d pc=%0d, required 1/4/4",
                     halted, retired_count, pm_addr);
        end
    endtask

    task automatic test_backpressure();
        fill_pm();
        pm[0] = 16'h1234;
        do_reset();
        run = 1'b1;
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            // Branch inputs must be ignored while no handshake happens.
            branch_taken  = 1'b1;
            branch_offset = 8'd9;
            tick();
            tests_run++;
            if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 5'd0 || retired_count !== 16'd0) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: valid=%b instr=%h pc=%0d cnt=%0d, required 1/1234/0/0",
                         c, instr_valid, instr, instr_pc, retired_count);
            end
        end
        branch_taken = 1'b0;
        instr_ready  = 1'b1;
        tick();
        run         = 1'b0;
        instr_ready = 1'b0;
        tests_run++;
        if (retired_count !== 16'd1 || instr_valid !== 1'b0 || pm_addr !== 5'd1) begin
            fails++;
            $display("FAIL backpressure_accept: cnt=%0d valid=%b pc=%0d, required 1/0/1",
                     retired_count, instr_valid, pm_addr);
        end
        tick();
        tick();
        tests_run++;
        if (retired_count !== 16'd1 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_once: cnt=%0d valid=%b, required 1/0", retired_count, instr_valid);
        end
    endtask

    task automatic test_branch();
        fill_pm();
        do_reset();
        run         = 1'b1;
        instr_ready = 1'b1;
        wait_valid();
        branch_taken  = 1'b1;
        branch_offset = 8'd22;
        tick();
        branch_taken = 1'b0;
        wait_valid();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd22 || instr !== 16'h4016) begin
            fails++;
            $display("FAIL branch_to_22: valid=%b pc=%0d instr=%h, required 1/22/4016",
                     instr_valid, instr_pc, instr);
        end
        branch_taken  = 1'b1;
        branch_offset = 8'd2;
        tick();
        branch_taken = 1'b0;
        tests_run++;
        if (pm_addr !== 5'd24) begin
            fails++;
            $display("FAIL branch_pc: pm_addr=%0d, required 24", pm_addr);
        end
        wait_valid();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd24 || instr !== 16'h4018) begin
            fails++;
            $display("FAIL branch_to_24: valid=%b pc=%0d instr=%h, required 1/24/4018",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_wrap_negative();
        fill_pm();
        do_reset();
        run         = 1'b1;
        instr_ready = 1'b1;
        wait_valid();
        branch_taken  = 1'b1;
        branch_offset = 8'd31;
        tick();
        branch_taken = 1'b0;
        wait_valid();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd31) begin
            fails++;
            $display("FAIL wrap_at_31: valid=%b pc=%0d, required 1/31", instr_valid, instr_pc);
        end
        tick();
        tests_run++;
        if (pm_addr !== 5'd0) begin
            fails++;
            $display("FAIL wrap_pc: pm_addr=%0d, required 0", pm_addr);
        end
        wait_valid();
        branch_taken  = 1'b1;
        branch_offset = 8'd3;
        tick();
        branch_taken = 1'b0;
        wait_valid();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd3) begin
            fails++;
            $display("FAIL fwd_to_3: valid=%b pc=%0d, required 1/3", instr_valid, instr_pc);
        end
        branch_taken  = 1'b1;
        branch_offset = 8'hFB;
        tick();
        branch_taken = 1'b0;
        wait_valid();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd30 || instr !== 16'h401E) begin
            fails++;
            $display("FAIL neg_to_30: valid=%b pc=%0d instr=%h, required 1/30/401e",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_single_step();
        int issued;
        fill_pm();
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        tests_run++;
        if (instr_valid !== 1'b0 || pm_addr !== 5'd0 || retired_count !== 16'd0) begin
            fails++;
            $display("FAIL step_idle: valid=%b pc=%0d cnt=%0d, required 0/0/0",
                     instr_valid, pm_addr, retired_count);
        end
        step = 1'b1;
        tick();
        step   = 1'b0;
        issued = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (instr_valid === 1'b1) issued++;
        end
        tests_run++;
        if (issued != 1 || retired_count !== 16'd1 || instr_valid !== 1'b0 || pm_addr !== 5'd1) begin
            fails++;
            $display("FAIL step_one: issued=%0d cnt=%0d valid=%b pc=%0d, required 1/1/0/1",
                     issued, retired_count, instr_valid, pm_addr);
        end
    endtask

    task automatic test_halt_priority();
        fill_pm();
        // Halt in ISSUE without handshake drops the held instruction.
        do_reset();
        run = 1'b1;
        wait_valid();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tests_run++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || retired_count !== 16'd0 || pm_addr !== 5'd0) begin
            fails++;
            $display("FAIL halt_no_ready: halted=%b valid=%b cnt=%0d pc=%0d, required 1/0/0/0",
                     halted, instr_valid, retired_count, pm_addr);
        end
        // Steps are ignored while halted.
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tests_run++;
        if (halted !== 1'b1 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL halt_step_ignored: halted=%b valid=%b, required 1/0", halted, instr_valid);
        end
        // Reset leaves HALT and returns to FETCH at pc 0.
        do_reset();
        tests_run++;
        if (halted !== 1'b0 || pm_addr !== 5'd0 || retired_count !== 16'd0) begin
            fails++;
            $display("FAIL halt_reset: halted=%b pc=%0d cnt=%0d, required 0/0/0",
                     halted, pm_addr, retired_count);
        end
        run = 1'b1;
        wait_valid();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin
            fails++;
            $display("FAIL halt_reset_fetch: valid=%b pc=%0d, required 1/0", instr_valid, instr_pc);
        end
        // Halt together with handshake: retire and advance first.
        halt_req    = 1'b1;
        instr_ready = 1'b1;
        tick();
        halt_req    = 1'b0;
        instr_ready = 1'b0;
        tests_run++;
        if (halted !== 1'b1 || retired_count !== 16'd1 || pm_addr !== 5'd1) begin
            fails++;
            $display("FAIL halt_with_accept: halted=%b cnt=%0d pc=%0d, required 1/1/1",
                     halted, retired_count, pm_addr);
        end
        // Halt in FETCH: nothing is issued.
        do_reset();
        run      = 1'b1;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        tests_run++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== 16'd0 || retired_count !== 16'd0) begin
            fails++;
            $display("FAIL halt_in_fetch: halted=%b valid=%b instr=%h cnt=%0d, required 1/0/0000/0",
                     halted, instr_valid, instr, retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_run_halt_word();
        test_backpressure();
        test_branch();
        test_wrap_negative();
        test_single_step();
        test_halt_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule : tb_fetch_sequencer

`default_nettype wire
